// File: rtl/mult8_pp_scheduler_if.sv
// Request/result bundle for mult8_pp_scheduler: two requester channels and one result channel.
interface mult8_pp_scheduler_if #(
  parameter int TAG_W = 4
);
  logic             req0_valid, req0_ready;
  logic [7:0]       req0_a, req0_b;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid, req1_ready;
  logic [7:0]       req1_a, req1_b;
  logic [TAG_W-1:0] req1_tag;
  logic             res_valid, res_ready;
  logic [15:0]      res_p;
  logic             res_id;
  logic [TAG_W-1:0] res_tag;

  modport master (
    output req0_valid, req0_a, req0_b, req0_tag,
    output req1_valid, req1_a, req1_b, req1_tag,
    output res_ready,
    input  req0_ready, req1_ready, res_valid, res_p, res_id, res_tag
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_tag,
    input  req1_valid, req1_a, req1_b, req1_tag,
    input  res_ready,
    output req0_ready, req1_ready, res_valid, res_p, res_id, res_tag
  );
endinterface

// File: rtl/mult8_pp_scheduler.sv
// Round-robin sequencer for an 8x8 multiply built from four 6x6 partial products.
// MULT_PP_SCHED_ZSKIP_EN: skip partial-product phases whose high operand slice is zero.
module mult8_pp_scheduler #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mult8_pp_scheduler_if.slave bus,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [2:0] {S_IDLE, S_LL, S_LH, S_HL, S_HH, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             id_q, id_d, last_q, last_d;
  logic [15:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel, take;
  logic [5:0]       mx, my;
  logic [11:0]      pp;
  logic [15:0]      pp_sh;
  logic             a_hz, b_hz;

  // On contention the requester not granted last time wins.
  assign sel  = bus.req1_valid & (~bus.req0_valid | ~last_q);
  assign bus.req0_ready = (state_q == S_IDLE) & ~sel & bus.req0_valid;
  assign bus.req1_ready = (state_q == S_IDLE) &  sel & bus.req1_valid;
  assign take = bus.req0_ready | bus.req1_ready;

  assign a_hz = (a_q[7:6] == 2'b00);
  assign b_hz = (b_q[7:6] == 2'b00);

  // Shared 6x6 multiplier: operand slices and weight chosen by the phase.
  always_comb begin
    mx = a_q[5:0];
    my = b_q[5:0];
    case (state_q)
      S_LH:    my = {4'b0, b_q[7:6]};
      S_HL:    mx = {4'b0, a_q[7:6]};
      S_HH:    begin mx = {4'b0, a_q[7:6]}; my = {4'b0, b_q[7:6]}; end
      default: ;
    endcase
  end

  assign pp = {6'b0, mx} * {6'b0, my};

  always_comb begin
    pp_sh = {4'b0, pp};
    case (state_q)
      S_LH, S_HL: pp_sh = {pp[9:0], 6'b0};
      S_HH:       pp_sh = {pp[3:0], 12'b0};
      default:    ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    id_d    = id_q;
    last_d  = last_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (take) begin
        a_d     = sel ? bus.req1_a   : bus.req0_a;
        b_d     = sel ? bus.req1_b   : bus.req0_b;
        tag_d   = sel ? bus.req1_tag : bus.req0_tag;
        id_d    = sel;
        last_d  = sel;
        acc_d   = '0;
        state_d = S_LL;
      end
      S_LL: begin
        acc_d   = acc_q + pp_sh;
        state_d = S_LH;
`ifdef MULT_PP_SCHED_ZSKIP_EN
        if (b_hz) state_d = a_hz ? S_DONE : S_HL;
`endif
      end
      S_LH: begin
        acc_d   = acc_q + pp_sh;
        state_d = S_HL;
`ifdef MULT_PP_SCHED_ZSKIP_EN
        if (a_hz) state_d = S_DONE;
`endif
      end
      S_HL: begin
        acc_d   = acc_q + pp_sh;
        state_d = S_HH;
`ifdef MULT_PP_SCHED_ZSKIP_EN
        if (b_hz) state_d = S_DONE;
`endif
      end
      S_HH: begin
        acc_d   = acc_q + pp_sh;
        state_d = S_DONE;
      end
      S_DONE: if (bus.res_ready) begin
        state_d = S_IDLE;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, ~&cnt_q};
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifndef MULT_PP_SCHED_ZSKIP_EN
  logic unused_hz;
  assign unused_hz = a_hz ^ b_hz;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      id_q    <= id_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.res_valid = (state_q == S_DONE);
  assign bus.res_p     = acc_q;
  assign bus.res_id    = id_q;
  assign bus.res_tag   = tag_q;
  assign busy          = (state_q != S_IDLE);
  assign op_count      = cnt_q;
endmodule

// File: doc/mult8_pp_scheduler.md
Name: mult8_pp_scheduler

Overview:
- Sequential 8x8 unsigned multiplier controller. It shares one internal 6x6 partial-product multiplier between two requesters.
- Uses the team's standard operand split: A_H=A[7:6], A_L=A[5:0], B_H=B[7:6], B_L=B[5:0]. The four partial products are issued over successive cycles and accumulated with shifts into an exact 16-bit product.
- Round-robin arbitration between requester 0 and requester 1, valid/ready handshakes on both sides. Sits in front of the multiplier evaluation datapath as its sequencer.

Parameters:
- TAG_W, 4, width of the opaque tag carried from request to result.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  requester 0 handshake accept.
- req0_a  in  8  requester 0 multiplicand.
- req0_b  in  8  requester 0 multiplier.
- req0_tag  in  TAG_W  requester 0 tag.
- req1_valid, req1_ready, req1_a, req1_b, req1_tag: same directions and widths, for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_p  out  16  product A*B.
- res_id  out  1  index of the requester that owns the result.
- res_tag  out  TAG_W  tag of the owning request.
- busy  out  1  high in any state other than IDLE.
- op_count  out  CNT_W  completed results; saturates at all-ones.

Behaviour:
- Reset values: all outputs 0, state IDLE, accumulator 0, last_grant=1 (so requester 0 wins the first contention).
- States: IDLE, LL, LH, HL, HH, DONE.
- Arbitration is done in IDLE only:
  - sel = requester 0 if only req0 is valid; requester 1 if only req1 is valid; if both are valid, the requester not equal to last_grant.
  - reqN_ready = (state==IDLE) & (sel==N) & reqN_valid. This is combinational, and at most one ready is high.
- On handshake: latch a, b, tag and id; clear the accumulator; set last_grant=id; move to LL.
- Phase work, one cycle each; the shared multiplier operands are zero-extended to 6 bits:
  - LL: acc += A_L*B_L.
  - LH: acc += (A_L*B_H)<<6.
  - HL: acc += (A_H*B_L)<<6.
  - HH: acc += (A_H*B_H)<<12.
- Phase order is LL->LH->HL->HH->DONE. The accumulator is 16 bits; the final sum never exceeds 0xFE01, so it never overflows.
- Timing: handshake in cycle C0, phases in C1..C4, DONE entered at C5 with res_valid=1. Latency from accept to res_valid is 5 cycles.
- DONE: res_p, res_id and res_tag are held stable while res_valid=1.
  - res_valid & res_ready -> IDLE on the next edge, res_valid drops, and op_count increments unless saturated.
  - No request can be accepted in the same cycle as result pop. Minimum issue interval is 6 cycles.
- res_ready held low: the block stays in DONE indefinitely and both readies stay low.
- A request withdrawn before its handshake is never recorded; requesters must hold valid until ready.
- rst_n asserted mid-operation: the block aborts immediately to the reset values. No result is produced and op_count is cleared.
- busy = (state != IDLE).

Optional Feature:
- Macro: MULT_PP_SCHED_ZSKIP_EN.
- Defined: zero-partial skip. LH is skipped if B_H==0, HL is skipped if A_H==0, HH is skipped if A_H==0 or B_H==0. LL always executes. The next state is the next non-skipped phase, or DONE. Latency is 2 to 5 cycles; res_p is unchanged.
- Undefined: fixed 5-cycle latency, all phases always execute.

Test Plan:
- req0 a=0xFF, b=0xFF, res_ready=1 -> res_valid exactly 5 cycles after handshake, res_p=0xFE01, res_id=0, op_count=1.
- req0 (0x12,0x34,tag 3) and req1 (0xC0,0x03,tag 9) asserted together from reset -> req0 is served first with res_p=0x03A8; req1 is served next with res_p=0x0240, res_tag=9. A further simultaneous pair is granted to req0 again (last_grant=1).
- res_ready=0 for 10 cycles after res_valid with a=0x80, b=0x80 -> res_p=0x4000 held stable, req0_ready/req1_ready stay 0, busy=1. Raising res_ready returns the block to IDLE on the next edge.
- rst_n pulsed low during phase HL of a=0xAA, b=0x55 -> all outputs 0 immediately and state IDLE. A subsequent request 0xAA*0x55 returns 0x3872.
- ZSKIP defined, a=0x3F, b=0x3F -> res_valid 2 cycles after handshake, res_p=0x0F81. With a=0x3F, b=0x7F, latency is 3 cycles and res_p=0x1F41. ZSKIP undefined, same stimuli -> 5 cycles each.
- 65540 back-to-back operations with CNT_W=16 -> op_count saturates at 0xFFFF.
